// File: rtl/bus_slave_port.sv
// Serial bus slave port: shifts in the offset and write data LSB first, runs one
// local memory access and shifts the read byte back out, with ACK/busy handshakes.
module bus_slave_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              S_SEL,
   input  logic              S_RW,
   input  logic              S_BUS_IN,
   output logic              S_BUS_OUT,
   output logic              S_DVALID,
   output logic              S_ACK,
   output logic              S_BSY,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_WE,
   output logic              MEM_RE,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAXW + 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, WACK, WDATA, WR, WDONE, RD, RLAT, RACK, RDATA
   } state_t;

   state_t             state, state_nx;
   logic               sel_q;
   logic               rw_q;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  rd_sr;
   logic               start;

   // sel_q resets high so a select already asserted at reset release is not an edge
   assign start = (state == IDLE) && S_SEL && !sel_q;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state != IDLE && !S_SEL) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:  if (start) state_nx = ADDR;
            ADDR:  if (cnt == CNT_W'(ADDR_W - 1)) state_nx = rw_q ? WACK : RD;
            WACK:  state_nx = WDATA;
            WDATA: if (cnt == CNT_W'(DATA_W - 1)) state_nx = WR;
            WR:    state_nx = WDONE;
            WDONE: state_nx = IDLE;
            RD:    state_nx = RLAT;
            RLAT:  state_nx = RACK;
            RACK:  state_nx = RDATA;
            RDATA: if (cnt == CNT_W'(DATA_W - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // MEM_ADDR doubles as the address shift register; after ADDR_W shifts bit 0 lands at [0]
   always_ff @(posedge CLK) begin
      if (RST) begin
         sel_q     <= 1'b1;
         rw_q      <= 1'b0;
         cnt       <= '0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         rd_sr     <= '0;
      end else begin
         sel_q <= S_SEL;
         case (state)
            IDLE: if (start) begin
               rw_q     <= S_RW;
               cnt      <= CNT_W'(1);
               MEM_ADDR <= {S_BUS_IN, MEM_ADDR[ADDR_W-1:1]};
            end
            ADDR: begin
               MEM_ADDR <= {S_BUS_IN, MEM_ADDR[ADDR_W-1:1]};
               cnt      <= cnt + 1'b1;
            end
            WACK, RACK: cnt <= '0;
            WDATA: begin
               MEM_WDATA <= {S_BUS_IN, MEM_WDATA[DATA_W-1:1]};
               cnt       <= cnt + 1'b1;
            end
            RLAT: rd_sr <= MEM_RDATA;
            RDATA: begin
               rd_sr <= rd_sr >> 1;
               cnt   <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign S_BSY     = (state != IDLE);
   assign S_ACK     = (state == WACK) || (state == WDONE) || (state == RACK);
   assign MEM_WE    = (state == WR);
   assign MEM_RE    = (state == RD);
   assign S_DVALID  = (state == RDATA);
   assign S_BUS_OUT = S_DVALID & rd_sr[0];

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: write, read, held select, abort and reset cases.
module tb_bus_slave_port;

   logic        CLK = 1'b0;
   logic        RST, S_SEL, S_RW, S_BUS_IN;
   logic        S_BUS_OUT, S_DVALID, S_ACK, S_BSY, MEM_WE, MEM_RE;
   logic [11:0] MEM_ADDR;
   logic [7:0]  MEM_WDATA, MEM_RDATA;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] m_ack, m_we, m_re, m_bsy, m_dv, m_bo;
   logic [11:0] a_at  [64];
   logic [7:0]  wd_at [64];
   logic [5:0]  o_at  [64];

   bus_slave_port #(.ADDR_W(12), .DATA_W(8)) dut (
      .CLK(CLK), .RST(RST), .S_SEL(S_SEL), .S_RW(S_RW), .S_BUS_IN(S_BUS_IN),
      .S_BUS_OUT(S_BUS_OUT), .S_DVALID(S_DVALID), .S_ACK(S_ACK), .S_BSY(S_BSY),
      .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE),
      .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Entered just after a rising edge; cycle 0 is the select edge. Memory returns
   // rdv in the cycle after a sampled MEM_RE.
   task automatic run_txn(input logic rw, input logic [11:0] a, input logic [7:0] wd,
                          input logic [7:0] rdv, input int abort_c, input int rst_c,
                          input int ncyc);
      logic re_prev = 1'b0;
      m_ack = '0; m_we = '0; m_re = '0; m_bsy = '0; m_dv = '0; m_bo = '0;
      for (int c = 0; c < ncyc; c++) begin
         S_SEL     = (abort_c < 0) || (c < abort_c);
         RST       = (c == rst_c);
         S_RW      = rw;
         S_BUS_IN  = 1'b1;
         if (c < 12) S_BUS_IN = a[c];
         else if (rw && c >= 13 && c <= 20) S_BUS_IN = wd[c-13];
         MEM_RDATA = re_prev ? rdv : 8'h00;
         @(negedge CLK);
         m_ack[c] = S_ACK;  m_we[c] = MEM_WE;   m_re[c] = MEM_RE;
         m_bsy[c] = S_BSY;  m_dv[c] = S_DVALID; m_bo[c] = S_BUS_OUT;
         a_at[c]  = MEM_ADDR;
         wd_at[c] = MEM_WDATA;
         o_at[c]  = {S_BUS_OUT, S_DVALID, S_ACK, S_BSY, MEM_WE, MEM_RE};
         re_prev  = MEM_RE;
         @(posedge CLK); #1;
      end
      RST = 1'b0;
   endtask

   task automatic sel_low_cycle();
      S_SEL = 1'b0;
      @(posedge CLK); #1;
   endtask

   initial begin
      int hits;
      RST = 1'b1; S_SEL = 1'b1; S_RW = 1'b0; S_BUS_IN = 1'b0; MEM_RDATA = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_outs",  {58'd0, S_BUS_OUT, S_DVALID, S_ACK, S_BSY, MEM_WE, MEM_RE}, 64'd0);
      chk("rst_addr",  64'(MEM_ADDR), 64'd0);
      chk("rst_wdata", 64'(MEM_WDATA), 64'd0);
      @(posedge CLK); #1;

      // select already high at reset release must not start
      RST = 1'b0;
      hits = 0;
      repeat (8) begin
         @(negedge CLK);
         if (S_BSY || MEM_RE || MEM_WE) hits++;
         @(posedge CLK); #1;
      end
      chk("rel_nostart", 64'(hits), 64'd0);
      sel_low_cycle();

      // write 0xAD to 0x5A3
      run_txn(1'b1, 12'h5A3, 8'hAD, 8'h00, -1, -1, 24);
      chk("wr_ack",   m_ack, (64'd1 << 12) | (64'd1 << 22));
      chk("wr_we",    m_we,  64'd1 << 21);
      chk("wr_re",    m_re,  64'd0);
      chk("wr_bsy",   m_bsy, rng(1, 22));
      chk("wr_addr",  64'(a_at[21]),  64'h5A3);
      chk("wr_wdata", 64'(wd_at[21]), 64'hAD);
      sel_low_cycle();

      // read 0x0F0 returning 0xB5, select then held high 40 more cycles
      run_txn(1'b0, 12'h0F0, 8'h00, 8'hB5, -1, -1, 64);
      chk("rd_re",   m_re,  64'd1 << 12);
      chk("rd_addr", 64'(a_at[12]), 64'h0F0);
      chk("rd_ack",  m_ack, 64'd1 << 14);
      chk("rd_dv",   m_dv,  rng(15, 22));
      chk("rd_bits", m_bo,  64'hB5 << 15);
      chk("rd_bsy",  m_bsy, rng(1, 22));
      chk("rd_we",   m_we,  64'd0);
      sel_low_cycle();

      // one-cycle select drop restarts
      run_txn(1'b0, 12'hFFF, 8'h00, 8'h3C, -1, -1, 24);
      chk("rd2_re",   m_re, 64'd1 << 12);
      chk("rd2_addr", 64'(a_at[12]), 64'hFFF);
      chk("rd2_bits", m_bo, 64'h3C << 15);
      sel_low_cycle();

      // write aborted by select drop at cycle 16
      run_txn(1'b1, 12'h001, 8'h55, 8'h00, 16, -1, 24);
      chk("ab_we",  m_we,  64'd0);
      chk("ab_ack", m_ack, 64'd1 << 12);
      chk("ab_bsy", m_bsy, rng(1, 16));

      // reset at cycle 17 of a read, select held high afterwards
      run_txn(1'b0, 12'h800, 8'h00, 8'hFF, -1, 17, 30);
      chk("rr_dv",    m_dv,  rng(15, 17));
      chk("rr_bits",  m_bo,  rng(15, 17));
      chk("rr_outs",  64'(o_at[18]), 64'd0);
      chk("rr_addr",  64'(a_at[18]), 64'd0);
      chk("rr_bsy",   m_bsy, rng(1, 17));
      chk("rr_re",    m_re,  64'd1 << 12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_slave_port.md
# bus_slave_port

Serial bus slave port that sits directly downstream of the bus master on the shared serial bus. It is selected by the address decoder and deserialises the slave-offset address and write data shifted out bit-serially by the master. It performs one access on a local synchronous memory port. For reads it serialises the returned byte back to the master, and it produces the ACK and busy handshakes the master waits on.

## Interface
- ADDR_W, 12: slave-local offset width (bits shifted by master after select)
- DATA_W, 8: data width

- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset; one clock; reset is synchronous and active-high
- S_SEL  in  1  slave select from address decoder; high for whole transaction
- S_RW  in  1  1 = write, 0 = read; sampled at start edge only
- S_BUS_IN  in  1  serial address/write data from master, LSB first
- S_BUS_OUT  out  1  serial read data to master, LSB first
- S_DVALID  out  1  high while S_BUS_OUT carries a read data bit
- S_ACK  out  1  one-cycle acknowledge pulse
- S_BSY  out  1  slave busy; high in every non-IDLE state
- MEM_ADDR  out  ADDR_W  local memory address (captured offset)
- MEM_WDATA  out  DATA_W  local memory write data
- MEM_WE  out  1  one-cycle write strobe
- MEM_RE  out  1  one-cycle read strobe
- MEM_RDATA  in  DATA_W  read data, valid the cycle after MEM_RE

## Operation
- States: IDLE, ADDR, WACK, WDATA, WR, WDONE, RD, RLAT, RACK, RDATA.
- Start: in IDLE, a transaction begins on a cycle with S_SEL=1 and S_SEL=0 on the previous cycle (rising-edge detect). That edge samples address bit 0 and S_RW. S_SEL held high after completion never retriggers.
- ADDR: samples address bits 1..ADDR_W-1, one per edge, into a shift register. After the last bit, the state goes to WACK (write) or RD (read).
- Write path: WACK (S_ACK=1) -> WDATA for DATA_W cycles, sampling S_BUS_IN LSB first -> WR (MEM_WE=1 with MEM_ADDR/MEM_WDATA stable) -> WDONE (S_ACK=1) -> IDLE.
- Read path: RD (MEM_RE=1) -> RLAT (MEM_RDATA captured at end of cycle) -> RACK (S_ACK=1) -> RDATA for DATA_W cycles (S_BUS_OUT = bit i, S_DVALID=1) -> IDLE.
- Abort: S_SEL=0 in any non-IDLE state -> IDLE at the next edge.
  - No S_ACK.
  - No MEM_WE is issued if WR has not yet been entered.
  - An already issued MEM_RE is harmless.
- No range check: the full ADDR_W offset is forwarded unchanged. Counters wrap only by reset/return to IDLE.
- S_BUS_IN value (including X/Z) is ignored outside sampling cycles.

## Timing
- All outputs are registered or Moore-decoded from state. No combinational input-to-output path.
- Reset: state IDLE.
  - S_BUS_OUT, S_DVALID, S_ACK, S_BSY, MEM_WE, MEM_RE = 0.
  - MEM_ADDR, MEM_WDATA = 0.
  - The edge-detect history register = 1, so S_SEL already high at reset release does not start.
- RST mid-transaction: IDLE at that edge. No further strobes.
- Cycle 0 is the start cycle (ADDR_W=12, DATA_W=8).
- Write timeline:
  - Address: cycles 0–11.
  - S_ACK: cycle 12.
  - Data bits: cycles 13–20.
  - MEM_WE: cycle 21.
  - S_ACK: cycle 22.
  - IDLE: cycle 23.
  - S_BSY high: cycles 1–22.
- Read timeline:
  - Address: cycles 0–11.
  - MEM_RE: cycle 12.
  - Latch: cycle 13.
  - S_ACK: cycle 14.
  - Data bits: cycles 15–22.
  - IDLE: cycle 23.
- The master drives write bit 0 in the cycle immediately after the S_ACK cycle. It samples read bit 0 in the cycle immediately after the S_ACK cycle.
- Back-to-back: a new transaction requires S_SEL low for at least one cycle. Earliest restart is cycle 24.

## Test plan
- Write: 0xAD to offset 0x5A3 -> MEM_WE high cycle 21 only, MEM_ADDR=0x5A3, MEM_WDATA=0xAD; S_ACK high cycles 12 and 22 only.
- Read: offset 0x0F0, memory returns 0xB5 -> MEM_RE cycle 12, MEM_ADDR=0x0F0; S_ACK cycle 14; S_BUS_OUT cycles 15–22 = 1,0,1,0,1,1,0,1 with S_DVALID high; S_BSY low at cycle 23.
- Abort: drop S_SEL at cycle 16 of a write -> state IDLE at cycle 17, no MEM_WE, no second S_ACK; S_BSY low from cycle 17.
- Reset mid-read: RST at cycle 17 -> all outputs 0 next cycle; S_DVALID never high again until a new select edge.
- Held select: keep S_SEL high for 40 cycles after a completed read -> exactly one transaction (one MEM_RE). Toggle S_SEL low for one cycle then high -> second transaction starts.
- Reset release with S_SEL already high -> no transaction until S_SEL goes low then high.
